// File: rtl/dot_operand_pingpong_buffer.sv
// dot_operand_pingpong_buffer
// Two-bank operand store for the dot-product datapath. One bank is filled
// element by element while the other, once committed, streams out LANES
// elements per beat over a valid/ready handshake.
// Optional feature: define DOT_BUF_ZERO_PAD_EN to keep a per-bank written mask
// so that elements never written since the bank was last released read as 0.
module dot_operand_pingpong_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int VECTOR_LEN = 16,
    parameter int LANES      = 2,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        write_en,
    input  logic [ADDR_WIDTH-1:0]       write_addr,
    input  logic [DATA_WIDTH-1:0]       data_a,
    input  logic [DATA_WIDTH-1:0]       data_b,
    input  logic                        wr_commit,
    output logic                        wr_ready,
    output logic                        wr_error,
    output logic                        rd_avail,
    input  logic                        start_reading,
    output logic [LANES*DATA_WIDTH-1:0] out_a,
    output logic [LANES*DATA_WIDTH-1:0] out_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [ADDR_WIDTH:0]         element_count,
    output logic                        reading_done
);

    localparam int NUM_BEATS = VECTOR_LEN / LANES;
    localparam logic [ADDR_WIDTH:0] VEC_LEN_W   = (ADDR_WIDTH+1)'(VECTOR_LEN);
    localparam logic [ADDR_WIDTH:0] NUM_BEATS_W = (ADDR_WIDTH+1)'(NUM_BEATS);
    localparam logic [ADDR_WIDTH:0] LAST_BEAT_W = (ADDR_WIDTH+1)'(NUM_BEATS - 1);
    localparam logic [ADDR_WIDTH:0] LANES_W     = (ADDR_WIDTH+1)'(LANES);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rd_state_t;

    // Bank storage; contents survive reset on purpose
    logic [DATA_WIDTH-1:0] mem_a_r [2][VECTOR_LEN];
    logic [DATA_WIDTH-1:0] mem_b_r [2][VECTOR_LEN];
`ifdef DOT_BUF_ZERO_PAD_EN
    logic [VECTOR_LEN-1:0] wmask_r [2];
`endif

    logic                        fill_sel_r;
    logic                        rd_sel_r;
    logic [1:0]                  bank_full_r;
    logic [1:0]                  bank_full_s;
    logic                        wr_error_r;
    rd_state_t                   state_r;
    rd_state_t                   state_nxt_s;
    logic [ADDR_WIDTH:0]         issue_beat_r;   // next beat to load into the output register
    logic [ADDR_WIDTH:0]         load_beat_s;
    logic                        wr_accept_s;
    logic                        wr_drop_s;
    logic                        commit_accept_s;
    logic                        commit_drop_s;
    logic                        start_s;
    logic                        accept_s;
    logic                        release_s;
    logic                        load_s;
    logic [ADDR_WIDTH-1:0]       lane_idx_s [LANES];
    logic [LANES*DATA_WIDTH-1:0] rd_a_s;
    logic [LANES*DATA_WIDTH-1:0] rd_b_s;
    logic                        out_valid_r;
    logic                        out_last_r;
    logic                        reading_done_r;
    logic [LANES*DATA_WIDTH-1:0] out_a_r;
    logic [LANES*DATA_WIDTH-1:0] out_b_r;
    logic [ADDR_WIDTH:0]         element_count_r;

    // Write-side acceptance: a full fill bank or an out-of-range address drops the request
    always_comb begin
        wr_accept_s     = write_en && !bank_full_r[fill_sel_r] && ({1'b0, write_addr} < VEC_LEN_W);
        wr_drop_s       = write_en && !wr_accept_s;
        commit_accept_s = wr_commit && !bank_full_r[fill_sel_r];
        commit_drop_s   = wr_commit && !commit_accept_s;
    end

    // Read FSM outputs: start, per-beat load and last-beat release decisions
    always_comb begin
        start_s     = (state_r == ST_IDLE) && start_reading && bank_full_r[rd_sel_r];
        accept_s    = out_valid_r && out_ready;
        release_s   = (state_r == ST_STREAM) && accept_s && out_last_r;
        load_s      = start_s ||
                      ((state_r == ST_STREAM) && (!out_valid_r || out_ready) &&
                       (issue_beat_r < NUM_BEATS_W));
        // Beat 0 is loaded straight from IDLE so the first beat appears one cycle after start
        load_beat_s = (state_r == ST_STREAM) ? issue_beat_r : {(ADDR_WIDTH+1){1'b0}};
    end

    // Read FSM next state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_nxt_s = ST_STREAM;
                else         state_nxt_s = ST_IDLE;
            end
            ST_STREAM: begin
                if (release_s) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_STREAM;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Read FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Bank occupancy: commit of the fill bank and release of the read bank never hit the same bank
    always_comb begin
        bank_full_s = bank_full_r;
        for (int b = 0; b < 2; b++) begin
            if (commit_accept_s && (fill_sel_r == 1'(b)))  bank_full_s[b] = 1'b1;
            else if (release_s && (rd_sel_r == 1'(b)))     bank_full_s[b] = 1'b0;
            else                                            bank_full_s[b] = bank_full_r[b];
        end
    end

    // Combinational gather of the LANES elements that form the beat being loaded
    always_comb begin
        rd_a_s = '0;
        rd_b_s = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_idx_s[k] = ADDR_WIDTH'(load_beat_s * LANES_W + (ADDR_WIDTH+1)'(k));
`ifdef DOT_BUF_ZERO_PAD_EN
            if (wmask_r[rd_sel_r][lane_idx_s[k]]) begin
                rd_a_s[k*DATA_WIDTH +: DATA_WIDTH] = mem_a_r[rd_sel_r][lane_idx_s[k]];
                rd_b_s[k*DATA_WIDTH +: DATA_WIDTH] = mem_b_r[rd_sel_r][lane_idx_s[k]];
            end else begin
                rd_a_s[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
                rd_b_s[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end
`else
            rd_a_s[k*DATA_WIDTH +: DATA_WIDTH] = mem_a_r[rd_sel_r][lane_idx_s[k]];
            rd_b_s[k*DATA_WIDTH +: DATA_WIDTH] = mem_b_r[rd_sel_r][lane_idx_s[k]];
`endif
        end
    end

    // Bank selectors, occupancy flags and the sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_sel_r  <= 1'b0;
            rd_sel_r    <= 1'b0;
            bank_full_r <= 2'b00;
            wr_error_r  <= 1'b0;
        end else begin
            fill_sel_r  <= commit_accept_s ? ~fill_sel_r : fill_sel_r;
            rd_sel_r    <= release_s ? ~rd_sel_r : rd_sel_r;
            bank_full_r <= bank_full_s;
            wr_error_r  <= wr_error_r | wr_drop_s | commit_drop_s;
        end
    end

    // Output beat register: loads a new beat, clears after the final handshake, holds on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r     <= 1'b0;
            out_last_r      <= 1'b0;
            out_a_r         <= '0;
            out_b_r         <= '0;
            element_count_r <= '0;
            issue_beat_r    <= '0;
            reading_done_r  <= 1'b0;
        end else begin
            reading_done_r <= release_s;
            if (load_s) begin
                out_valid_r     <= 1'b1;
                out_a_r         <= rd_a_s;
                out_b_r         <= rd_b_s;
                out_last_r      <= (load_beat_s == LAST_BEAT_W);
                element_count_r <= load_beat_s * LANES_W;
                issue_beat_r    <= load_beat_s + (ADDR_WIDTH+1)'(1);
            end else if (accept_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    // Element storage write port into the fill bank
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_a_r[fill_sel_r][write_addr] <= data_a;
            mem_b_r[fill_sel_r][write_addr] <= data_b;
        end
    end

`ifdef DOT_BUF_ZERO_PAD_EN
    // Written-element mask per bank, cleared when the bank is released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wmask_r[0] <= '0;
            wmask_r[1] <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (release_s && (rd_sel_r == 1'(b)))
                    wmask_r[b] <= '0;
                else if (wr_accept_s && (fill_sel_r == 1'(b)))
                    wmask_r[b][write_addr] <= 1'b1;
                else
                    wmask_r[b] <= wmask_r[b];
            end
        end
    end
`endif

    assign wr_ready      = !bank_full_r[fill_sel_r];
    assign rd_avail      = bank_full_r[rd_sel_r];
    assign wr_error      = wr_error_r;
    assign out_valid     = out_valid_r;
    assign out_a         = out_a_r;
    assign out_b         = out_b_r;
    assign out_last      = out_last_r;
    assign element_count = element_count_r;
    assign reading_done  = reading_done_r;

endmodule
